// File: rtl/linemem_access_ctrl_pkg.sv
// Shared size codes, FSM state encodings and small helpers for the LineMemory
// access controller.
package linemem_access_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    LMA_IDLE = 3'd0,
    LMA_RD0  = 3'd1,
    LMA_RD1  = 3'd2,
    LMA_CAP  = 3'd3,
    LMA_WR0  = 3'd4,
    LMA_WR1  = 3'd5,
    LMA_RSP  = 3'd6
  } lma_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 32'h0000_00FF;
      SZ_H:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/linemem_lane_merge.sv
// Combinational byte-lane logic: merges store data into a pair of old words and
// extracts a zero/sign-extended load result from a pair of read words.
module linemem_lane_merge
  import linemem_access_ctrl_pkg::*;
(
  input  logic [31:0] old_lo,
  input  logic [31:0] old_hi,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] new_lo,
  output logic [31:0] new_hi,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                         input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (sz)
      SZ_B:    return sgn ? 32'(b) : {24'h0, raw[7:0]};
      SZ_H:    return sgn ? 32'(h) : {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  logic [63:0] pair;
  logic [63:0] mask;
  logic [63:0] sdata;
  logic [63:0] merged;
  logic [5:0]  shamt;

  always_comb begin
    shamt   = {1'b0, lane, 3'b000};
    pair    = {old_hi, old_lo};
    mask    = {32'h0, size_mask(size)} << shamt;
    sdata   = {32'h0, wdata} << shamt;
    // Only lanes under the mask take store data; everything else keeps the old bytes.
    merged  = (pair & ~mask) | (sdata & mask);
    new_lo  = merged[31:0];
    new_hi  = merged[63:32];
    ld_data = extend(32'(pair >> shamt), size, sign);
  end

endmodule

// File: rtl/linemem_access_ctrl.sv
// Initiator for the LineMemory port: converts byte/half/word, possibly unaligned
// load/store requests into word reads and read-modify-write word writes.
module linemem_access_ctrl
  import linemem_access_ctrl_pkg::*;
#(
  parameter int BADDR_W = 16,
  parameter int WADDR_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_sign,
  input  logic [BADDR_W-1:0] req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               mem_en,
  output logic               mem_we,
  output logic [WADDR_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  lma_state_e state_q, state_d;

  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               sign_q, sign_d;
  logic               span_q, span_d;
  logic [1:0]         lane_q, lane_d;
  logic [WADDR_W-1:0] w0_q, w0_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi_q, hi_d;

  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [WADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic [1:0]         req_lane;
  logic [WADDR_W-1:0] req_w0;
  logic               req_span;
  logic               req_err;
  logic               req_wstore;
  logic [WADDR_W-1:0] w1;
  logic [31:0]        mrg_lo, mrg_hi, ld_data;

  always_comb begin
    req_lane   = req_addr[1:0];
    req_w0     = req_addr[BADDR_W-1:2];
    req_span   = ({1'b0, req_lane} + size_bytes(req_size)) > 3'd4;
    // A span starting in the last word would wrap to word 0, so it traps instead.
    req_err    = (req_size == 2'b11) || (req_span && (&req_w0));
    req_wstore = req_we && (req_size == SZ_W) && (req_lane == 2'b00);
    w1         = w0_q + WADDR_W'(1);
  end

  // In CAP the last-read word is still on mem_rdata; a span's first word was parked in lo_q.
  linemem_lane_merge u_merge (
    .old_lo  (span_q ? lo_q : mem_rdata),
    .old_hi  (mem_rdata),
    .wdata   (wdata_q),
    .lane    (lane_q),
    .size    (size_q),
    .sign    (sign_q),
    .new_lo  (mrg_lo),
    .new_hi  (mrg_hi),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sign_d      = sign_q;
    span_d      = span_q;
    lane_d      = lane_q;
    w0_d        = w0_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      LMA_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sign_d  = req_sign;
          span_d  = req_span;
          lane_d  = req_lane;
          w0_d    = req_w0;
          wdata_d = req_wdata;
          if (req_err) begin
            state_d     = LMA_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (req_wstore) begin
            state_d     = LMA_WR0;
            mem_addr_d  = req_w0;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = LMA_RD0;
            mem_addr_d = req_w0;
          end
        end
      end
      LMA_RD0: begin
        if (span_q) begin
          state_d    = LMA_RD1;
          mem_addr_d = w1;
        end else begin
          state_d = LMA_CAP;
        end
      end
      LMA_RD1: begin
        lo_d    = mem_rdata;
        state_d = LMA_CAP;
      end
      LMA_CAP: begin
        if (we_q) begin
          hi_d        = mrg_hi;
          mem_addr_d  = w0_q;
          mem_wdata_d = mrg_lo;
          state_d     = LMA_WR0;
        end else begin
          rsp_rdata_d = ld_data;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = LMA_RSP;
        end
      end
      LMA_WR0: begin
        if (span_q) begin
          mem_addr_d  = w1;
          mem_wdata_d = hi_q;
          state_d     = LMA_WR1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          state_d     = LMA_RSP;
        end
      end
      LMA_WR1: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        state_d     = LMA_RSP;
      end
      LMA_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          state_d     = LMA_IDLE;
        end
      end
      default: state_d = LMA_IDLE;
    endcase

    // Strobes are decoded from the next state so they are registered yet aligned with it.
    mem_en_d = (state_d == LMA_RD0) || (state_d == LMA_RD1) ||
               (state_d == LMA_WR0) || (state_d == LMA_WR1);
    mem_we_d = (state_d == LMA_WR0) || (state_d == LMA_WR1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LMA_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Request latches and read captures are only meaningful once the FSM has left IDLE.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    size_q  <= size_d;
    sign_q  <= sign_d;
    span_q  <= span_d;
    lane_q  <= lane_d;
    w0_q    <= w0_d;
    wdata_q <= wdata_d;
    lo_q    <= lo_d;
    hi_q    <= hi_d;
  end

  assign req_ready = (state_q == LMA_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_linemem_access_ctrl.sv
// Bench for linemem_access_ctrl: word-addressed memory model, vector table with a
// response scoreboard, hand sequences for back-pressure and mid-operation reset.
module tb_linemem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        clr_mem;

  logic [31:0] mem [0:16383];
  logic [7:0]  refmem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] erd;
    logic        eerr;
    int          elat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  linemem_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // LineMemory model: one-cycle read latency, no byte enables.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic int exp_lat(input logic we, input logic [1:0] size, input logic [15:0] addr);
    int  lane = int'(addr[1:0]);
    bit  span = (lane + nbytes(size)) > 4;
    if (size == 2'b11 || (span && addr[15:2] == 14'h3FFF)) return 1;
    if (we) return (size == 2'b10 && lane == 0) ? 2 : (span ? 6 : 4);
    return span ? 4 : 3;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign,
                                           input logic [15:0] addr);
    logic [31:0] v = 32'h0;
    int n = nbytes(size);
    for (int b = 0; b < n; b++) v[8*b +: 8] = refmem[addr + 16'(b)];
    if (sign && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (sign && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Drives one request at the current negedge (DUT must be idle) and checks its response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] erd, input logic eerr, input int elat,
                        input string nm);
    exp_t e;
    bit   got = 0, en_seen = 0, rdy_bad = 0;
    int   k;
    sb_q.push_back('{erd, eerr, elat});
    chk({nm, " ready_before"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_we = ~we; req_size = $urandom_range(0, 3);
        req_sign = ~sign; req_addr = 16'($urandom); req_wdata = $urandom;
      end
      if (mem_en) en_seen = 1;
      if (req_ready) rdy_bad = 1;
      if (rsp_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: no rsp_valid within 20 cycles", nm);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      chk({nm, " rdata"},   rsp_rdata, e.rdata);
      chk({nm, " err"},     {31'h0, rsp_err}, {31'h0, e.err});
      chk({nm, " latency"}, 32'(k), 32'(e.lat));
      chk({nm, " busy_ready_low"}, {31'h0, rdy_bad}, 32'h0);
      if (e.err) chk({nm, " no_mem_access"}, {31'h0, en_seen}, 32'h0);
    end
    @(negedge clk);
    chk({nm, " rsp_dropped"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] held;
    bit          seen;

    for (int i = 0; i < 65536; i++) refmem[i] = 8'h0;
    rst = 1'b1; clr_mem = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
    req_addr = 16'h0; req_wdata = 32'h0;

    vecs.push_back('{1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 3});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 16'h0010, 32'h11223344, 32'h0,        1'b0, 2});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 16'h0013, 32'h00000080, 32'h0,        1'b0, 4});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 16'h0013, 32'h0,        32'hFFFFFF80, 1'b0, 3});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 16'h0013, 32'h0,        32'h00000080, 1'b0, 3});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        32'h80223344, 1'b0, 3});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 16'h0022, 32'hAABBCCDD, 32'h0,        1'b0, 6});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 16'h0022, 32'h0,        32'hAABBCCDD, 1'b0, 4});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 16'hFFFF, 32'h0,        32'h0,        1'b1, 1});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 16'h0040, 32'h0,        32'h0,        1'b1, 1});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 16'h0040, 32'h12345678, 32'h0,        1'b1, 1});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 16'hFFFE, 32'h12345678, 32'h0,        1'b1, 1});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 16'h0025, 32'hFFFF1234, 32'h0,        1'b0, 4});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 16'h0025, 32'h0,        32'h00001234, 1'b0, 3});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 16'h0023, 32'h0,        32'hFFFFBBCC, 1'b0, 4});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 16'hFFFF, 32'hFFFFFF5A, 32'h0,        1'b0, 4});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 16'hFFFF, 32'h0,        32'h0000005A, 1'b0, 3});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 16'hFFFC, 32'h0,        32'h5A000000, 1'b0, 3});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 16'h0033, 32'h0000BEEF, 32'h0,        1'b0, 6});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 16'h0033, 32'h0,        32'h0000BEEF, 1'b0, 4});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 16'h0034, 32'h0,        32'hFFFFFFBE, 1'b0, 3});

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("reset_outputs", {mem_en, mem_we, rsp_valid, rsp_err, 28'h0},  32'h0);
    chk("reset_mem_addr", {18'h0, mem_addr}, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    clr_mem = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata,
             vecs[i].erd, vecs[i].eerr, vecs[i].elat, $sformatf("vec%0d", i));
      if (i == 3) chk("mem_word4_after_byte_store", mem[4], 32'h80223344);
      if (i == 7) begin
        chk("mem_word8_after_span", mem[8], 32'hCCDD0000);
        chk("mem_word9_after_span", mem[9], 32'h0000AABB);
      end
    end
    chk("mem_word9_final", mem[9], 32'h001234BB);
    chk("mem_word12_final", mem[12], 32'hEF000000);
    chk("mem_word13_final", mem[13], 32'h000000BE);

    // Back-pressure: rsp_ready low for 5 cycles
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0;
    req_addr = 16'h0010; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (rsp_valid) seen = 1;
      else @(negedge clk);
    end
    chk("bp_rsp_seen", {31'h0, seen}, 32'h1);
    held = 32'h80223344;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_c%0d", k), {31'h0, rsp_valid}, 32'h1);
      chk($sformatf("bp_rdata_c%0d", k), rsp_rdata, held);
      chk($sformatf("bp_ready_c%0d", k), {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", {31'h0, rsp_valid}, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 16'h0012, 32'h0, 32'h00000022, 1'b0, 3, "bp_next_req");

    // Reset during WR1 of a span store at 0x0042 (words 16,17)
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_sign = 1'b0;
    req_addr = 16'h0042; req_wdata = 32'h01020304;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      if (mem_en && mem_we && mem_addr == 14'd17) seen = 1;
      else @(negedge clk);
    end
    chk("rst_wr1_reached", {31'h0, seen}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {mem_en, mem_we, rsp_valid, rsp_err, req_ready, 27'h0}, 32'h0);
    chk("rst_mid_addr", {18'h0, mem_addr}, 32'h0);
    chk("rst_mid_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_word16_kept", mem[16], 32'h03040000);
    chk("rst_word17_untouched", mem[17], 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 16'h0040, 32'h0, 32'h03040000, 1'b0, 3, "post_rst_load");

    // Random traffic against a byte-array reference model
    for (int i = 0; i < 40; i++) begin
      logic        we, sg;
      logic [1:0]  sz;
      logic [15:0] ad;
      logic [31:0] wd, erd;
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      ad = 16'h0100 + 16'($urandom_range(0, 31));
      wd = $urandom;
      erd = we ? 32'h0 : ref_load(sz, sg, ad);
      if (we) for (int b = 0; b < nbytes(sz); b++) refmem[ad + 16'(b)] = wd[8*b +: 8];
      do_req(we, sz, sg, ad, wd, erd, 1'b0, exp_lat(we, sz, ad), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
